inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction entries (power of two, >= 2).
REQ-002 SHALL have parameter PTR_W, default 3, log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, discard all entries (branch mispredict / exception redirect).
REQ-006 SHALL have port enq_valid, input, 1, fetch presents an instruction.
REQ-007 SHALL have port enq_inst, input, 32, fetched instruction word.
REQ-008 SHALL have port enq_pc, input, 32, PC of enq_inst.
REQ-009 SHALL have port enq_ready, output, 1, queue accepts an instruction this cycle.
REQ-010 SHALL have port deq_valid, output, 1, head entry presented to the decoder.
REQ-011 SHALL have port deq_inst, output, 32, head instruction word, driven to the decoder's inst input.
REQ-012 SHALL have port deq_pc, output, 32, PC of head instruction.
REQ-013 SHALL have port deq_ready, input, 1, decode/dispatch consumes head (low when ROB or target FU queue full).
REQ-014 SHALL have port count, output, PTR_W+1, number of valid entries.

Function
REQ-015 SHALL be a circular FIFO: head and tail pointers of PTR_W bits wrapping DEPTH-1 -> 0, plus an occupancy counter of PTR_W+1 bits.
REQ-016 SHALL enqueue when enq_valid & enq_ready & !flush: write {enq_inst, enq_pc} at tail, tail += 1.
REQ-017 SHALL dequeue when deq_valid & deq_ready: head += 1.
REQ-018 SHALL drive enq_ready = (count != DEPTH); depends on stored state only, never on deq_ready (no same-cycle pass-through when full).
REQ-019 SHALL drive deq_valid = (count != 0) & !flush.
REQ-020 SHALL drive deq_inst/deq_pc from the head entry combinationally when deq_valid = 1, and 32'h0 when deq_valid = 0.
REQ-021 SHALL have enqueue-to-dequeue latency of one cycle: an entry written at edge N is visible on deq_* after edge N; no combinational bypass from enq_* to deq_*.
REQ-022 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-023 SHALL update count +1 on enqueue only, -1 on dequeue only; count never exceeds DEPTH nor drops below 0.
REQ-024 SHALL, when flush = 1, at the next edge set head = tail = 0 and count = 0; any enq_valid in that cycle is dropped and no dequeue occurs (deq_valid forced 0).
REQ-025 SHALL give rst priority over flush, and flush priority over enqueue/dequeue.
REQ-026 SHALL preserve entry order exactly across pointer wrap-around.
REQ-027 SHALL leave stored entry contents unmodified by flush/reset (only pointers and count cleared); stale data SHALL NOT reach deq_* because of REQ-020.

Reset
REQ-028 SHALL, with rst = 1 at an edge, set head = 0, tail = 0, count = 0.
REQ-029 SHALL present after reset: enq_ready = 1, deq_valid = 0, deq_inst = 0, deq_pc = 0, count = 0.
REQ-030 SHALL, on reset asserted mid-operation (queue partially full, enq/deq active), discard all entries and ignore that cycle's enqueue.

Verification
REQ-031 SHALL cover: reset, then enq inst 32'h00500093 pc 32'h0 with deq_ready = 0 -> next cycle deq_valid = 1, deq_inst = 32'h00500093, deq_pc = 32'h0, count = 1.
REQ-032 SHALL cover: 8 enqueues pc 0x00..0x1C, deq_ready = 0 -> count = 8, enq_ready = 0; 9th enq_valid dropped; then deq_ready = 1 for 8 cycles -> pcs 0x00..0x1C in order, then deq_valid = 0.
REQ-033 SHALL cover: count = 8, enq_valid = 1 and deq_ready = 1 same cycle -> only dequeue occurs, count = 7, enq_ready = 1 next cycle.
REQ-034 SHALL cover: count = 4, steady enq+deq for 20 cycles -> count stays 4, pointers wrap, output pc sequence strictly +4 with no gaps or repeats.
REQ-035 SHALL cover: count = 5, flush = 1 with enq_valid = 1 -> deq_valid = 0 in flush cycle; next cycle count = 0, deq_valid = 0; subsequent enq of pc 32'h80 appears as first output.
REQ-036 SHALL cover: count = 3, rst = 1 and flush = 1 together -> next cycle all outputs at REQ-029 values.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer with occupancy counter; flush and reset clear pointers only.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  output logic             enq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]    inst_mem [DEPTH];
  logic [31:0]    pc_mem   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;
  logic           do_enq;
  logic           do_deq;

  assign enq_ready = (cnt != FULL);
  assign deq_valid = (cnt != '0) & ~flush;
  assign do_enq    = enq_valid & enq_ready & ~flush;
  assign do_deq    = deq_valid & deq_ready;
  assign count     = cnt;

  // Gate on deq_valid so stale entries never leak after flush/reset
  always_comb begin
    deq_inst = '0;
    deq_pc   = '0;
    if (deq_valid) begin
      deq_inst = inst_mem[head];
      deq_pc   = pc_mem[head];
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      inst_mem[tail] <= enq_inst;
      pc_mem[tail]   <= enq_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_enq)
        tail <= tail + 1'b1;
      if (do_deq)
        head <= head + 1'b1;
      unique case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        enq_valid = 0;
  logic [31:0] enq_inst = '0;
  logic [31:0] enq_pc = '0;
  logic        enq_ready;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        deq_ready = 0;
  logic [PTR_W:0] count;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc),
    .deq_ready(deq_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   m_cnt = 0;
  bit   started = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model: occupancy plus ordered list of expected entries
  always @(posedge clk) begin
    if (rst || flush) begin
      if (rst) started = 1;
      sb.delete();
      m_cnt = 0;
    end else begin
      bit acc_e, acc_d;
      acc_d = deq_ready && m_cnt > 0;
      acc_e = enq_valid && m_cnt < DEPTH;
      if (acc_e) sb.push_back('{enq_inst, enq_pc});
      m_cnt = m_cnt + int'(acc_e) - int'(acc_d);
    end
  end

  // Monitor: compare observable state and pop on each handshake
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("enq_ready", 32'(enq_ready), 32'(m_cnt != DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'(m_cnt != 0 && !flush));
      if (deq_valid) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL deq_empty: got valid=1 expected no entry at %0t",
                   $time);
        end else begin
          chk("deq_inst", deq_inst, sb[0].inst);
          chk("deq_pc", deq_pc, sb[0].pc);
          if (deq_ready) void'(sb.pop_front());
        end
      end else begin
        chk("deq_inst_zero", deq_inst, 32'h0);
        chk("deq_pc_zero", deq_pc, 32'h0);
      end
    end
  end

  task automatic cyc(input logic r, input logic f, input logic ev,
                     input logic [31:0] ins, input logic [31:0] pc,
                     input logic dr);
    rst = r;
    flush = f;
    enq_valid = ev;
    enq_inst = ins;
    enq_pc = pc;
    deq_ready = dr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  int pc_n;

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // single enqueue, visible next cycle
    cyc(0, 0, 1, 32'h00500093, 32'h0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // fill to full, drop a 9th, then drain in order
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, mk(i*4), 32'(i*4), 0);
    cyc(0, 0, 1, mk(32'h20), 32'h20, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0, 1);

    // full with enq+deq: only dequeue happens
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, mk(i*4), 32'(i*4), 0);
    cyc(0, 0, 1, mk(32'h40), 32'h40, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // drain to 4, then steady enq+deq across wrap
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    pc_n = 32'h20;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, mk(32'(pc_n)), 32'(pc_n), 1);
      pc_n += 4;
    end

    // count 5, flush with enq_valid, then fresh entry
    cyc(0, 0, 1, mk(32'(pc_n)), 32'(pc_n), 0);
    cyc(0, 1, 1, mk(32'h100), 32'h100, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, mk(32'h80), 32'h80, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // count 3, reset and flush together with traffic
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, mk(32'(i*4)), 32'(i*4), 0);
    cyc(1, 1, 1, mk(32'h200), 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // random traffic
    pc_n = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic r, f, ev, dr;
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 5);
      ev = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 55);
      cyc(r, f, ev, $urandom, 32'(pc_n), dr);
      pc_n += 4;
    end

    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
